axi_wr_engine: RTL and testbench

AXI_WR_ENGINE -- requirements
Module: axi_wr_engine

---
 rtl/axi_wr_engine.sv | 135 +++++++++++++
 tb/tb_axi_wr_engine.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_engine.sv
// Write engine that turns one cache write request (byte/half/word or a 16-byte line)
// into a single AXI3 write transaction: AW, then W beats, then B. One transaction at a time.
module axi_wr_engine (
    input  logic         clk,
    input  logic         resetn,
    // cache side
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    // status for the read path
    output logic         wr_busy,
    output logic [31:0]  wr_busy_addr,
    // AW channel
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic [1:0]   awlock,
    output logic [3:0]   awcache,
    output logic [2:0]   awprot,
    output logic         awvalid,
    input  logic         awready,
    // W channel
    output logic [3:0]   wid,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    // B channel
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         run_q;
    logic [2:0]   type_q;
    logic [31:0]  addr_q;
    logic [3:0]   strb_q;
    logic [127:0] data_q;

    logic         is_line;
    logic         accept;
    logic         last_beat;
    logic [1:0]   len_lo;

    // The response ID and status carry no information for this engine.
    logic unused_b;
    assign unused_b = ^{bid, bresp};

    assign is_line   = type_q[2];
    assign len_lo    = is_line ? 2'd3 : 2'd0;
    assign last_beat = (cnt_q == len_lo);
    assign accept    = wr_req && wr_rdy;

    // run_q keeps wr_rdy low during reset and until the first edge after release.
    assign wr_rdy       = run_q && (state_q == S_IDLE);
    assign wr_busy      = (state_q != S_IDLE);
    assign wr_busy_addr = {addr_q[31:4], 4'b0000};

    assign awid    = 4'd1;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awaddr  = is_line ? {addr_q[31:4], 4'b0000} : addr_q;
    assign awlen   = {6'd0, len_lo};
    assign awsize  = is_line ? 3'd2 : {1'b0, type_q[1:0]};
    assign awvalid = (state_q == S_ADDR);

    assign wid    = 4'd1;
    assign wdata  = data_q[{cnt_q, 5'b00000} +: 32];
    assign wstrb  = is_line ? 4'hf : strb_q;
    assign wlast  = (state_q == S_DATA) && last_beat;
    assign wvalid = (state_q == S_DATA);

    assign bready = (state_q == S_RESP);

    // NOTE: every variable assigned here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_ADDR;
            S_ADDR: if (awready) begin
                state_d = S_DATA;
                cnt_d   = 2'd0;
            end
            S_DATA: if (wready) begin
                cnt_d = cnt_q + 2'd1;
                if (last_beat) state_d = S_RESP;
            end
            S_RESP: if (bvalid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the 128-bit line buffer is reset too, because wr_busy_addr and the
    // AXI outputs decode directly from these registers and must read zero in reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            run_q   <= 1'b0;
            type_q  <= 3'd0;
            addr_q  <= 32'd0;
            strb_q  <= 4'd0;
            data_q  <= 128'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
            if (accept) begin
                type_q <= wr_type;
                addr_q <= wr_addr;
                strb_q <= wr_wstrb;
                data_q <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_engine.sv
// Scoreboard bench for axi_wr_engine: directed requests push expected AW/W beats,
// a negedge monitor pops and compares them on each handshake.
module tb_axi_wr_engine;

    logic         clk = 1'b0;
    logic         resetn;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy, wr_busy;
    logic [31:0]  wr_busy_addr;
    logic [3:0]   awid, wid, bid;
    logic [31:0]  awaddr, wdata;
    logic [7:0]   awlen;
    logic [2:0]   awsize, awprot;
    logic [1:0]   awburst, awlock, bresp;
    logic [3:0]   awcache, wstrb;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    axi_wr_engine dut (
        .clk(clk), .resetn(resetn),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_busy(wr_busy), .wr_busy_addr(wr_busy_addr),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] addr; logic [7:0] len; logic [2:0] size; } aw_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } w_t;

    aw_t exp_aw[$];
    w_t  exp_w[$];
    int  tests = 0;
    int  fails = 0;
    int  aw_hs = 0;
    int  aw_stall = 0;

    // slave behaviour knobs
    int aw_delay = 0, b_delay = 0, w_toggle = 0, b_always = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
        aw_t e;
        e.addr = a; e.len = l; e.size = s;
        exp_aw.push_back(e);
    endtask

    task automatic push_w(input logic [31:0] d, input logic [3:0] s, input logic l);
        w_t e;
        e.data = d; e.strb = s; e.last = l;
        exp_w.push_back(e);
    endtask

    task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                         input logic [127:0] d);
        int n;
        n = 0;
        while (!wr_rdy && n < 200) begin
            @(posedge clk); #1; n++;
        end
        wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d; wr_req = 1'b1;
        @(posedge clk); #1;
        wr_req = 1'b0;
    endtask

    // Counts clock edges from the acceptance edge until wr_rdy returns.
    task automatic wait_done(output int n);
        n = 1;
        while (!wr_rdy && n < 200) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic check_drained(input string name);
        check({name, "_aw_left"}, 64'(exp_aw.size()), 64'd0);
        check({name, "_w_left"}, 64'(exp_w.size()), 64'd0);
    endtask

    // AXI slave model, updated just after each rising edge
    initial begin
        int aw_cnt, b_cnt;
        logic w_tog;
        aw_cnt = 0; b_cnt = 0; w_tog = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 4'd1; bresp = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
            else begin awready = 1'b0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_toggle != 0) ? w_tog : 1'b1; w_tog = ~w_tog; end
            else begin wready = 1'b0; w_tog = 1'b0; end
            if (b_always != 0) bvalid = 1'b1;
            else if (bready) begin bvalid = (b_cnt >= b_delay); b_cnt++; end
            else begin bvalid = 1'b0; b_cnt = 0; end
        end
    end

    // Monitor: handshakes are decided by the values seen at the falling edge
    initial begin
        aw_t ea;
        w_t  ew;
        logic [36:0] w_held;
        logic w_held_v;
        w_held_v = 1'b0; w_held = '0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (awvalid && !awready) aw_stall++;
                if (awvalid && awready) begin
                    aw_hs++;
                    if (exp_aw.size() == 0) check("unexpected_aw", 64'd1, 64'd0);
                    else begin
                        ea = exp_aw.pop_front();
                        check("aw_fields",
                              {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot},
                              {4'd1, ea.addr, ea.len, ea.size, 2'b01, 2'b00, 4'd0, 3'd0});
                    end
                end
                if (w_held_v && wvalid) check("w_stable", {wdata, wstrb, wlast}, w_held);
                w_held_v = wvalid && !wready;
                w_held   = {wdata, wstrb, wlast};
                if (wvalid && wready) begin
                    if (exp_w.size() == 0) check("unexpected_w", 64'd1, 64'd0);
                    else begin
                        ew = exp_w.pop_front();
                        check("w_beat", {wid, wdata, wstrb, wlast}, {4'd1, ew.data, ew.strb, ew.last});
                    end
                end
            end else begin
                w_held_v = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, nresp, base;
        resetn = 1'b0; wr_req = 1'b0; wr_type = 3'd0; wr_addr = 32'd0; wr_wstrb = 4'd0; wr_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {wr_rdy, wr_busy, awvalid, wvalid, wlast, bready}, 6'b000000);
        check("rst_busy_addr", wr_busy_addr, 32'd0);
        #2 resetn = 1'b1;
        #1 check("rdy_before_edge", wr_rdy, 1'b0);
        @(posedge clk); #1;
        check("rdy_after_edge", wr_rdy, 1'b1);

        // Line write, everything ready, bvalid high even outside RESP
        b_always = 1;
        push_aw(32'h1c000120, 8'd3, 3'd2);
        push_w(32'h11, 4'hf, 1'b0); push_w(32'h22, 4'hf, 1'b0);
        push_w(32'h33, 4'hf, 1'b0); push_w(32'h44, 4'hf, 1'b1);
        issue(3'b100, 32'h1c000124, 4'h0, {32'h44, 32'h33, 32'h22, 32'h11});
        check("line_busy", {wr_busy, wr_rdy}, 2'b10);
        check("line_busy_addr", wr_busy_addr, 32'h1c000120);
        wait_done(n);
        check("line_cycles", n, 7);
        check_drained("line");
        b_always = 0;

        // Byte write
        push_aw(32'h800000a3, 8'd0, 3'd0);
        push_w(32'haabbccdd, 4'b1000, 1'b1);
        issue(3'b000, 32'h800000a3, 4'b1000, {32'hffff0003, 32'h2, 32'h1, 32'haabbccdd});
        wait_done(n);
        check("byte_cycles", n, 4);
        check_drained("byte");

        // Backpressure: awready late by 3 cycles, wready toggling
        aw_delay = 3; w_toggle = 1;
        base = aw_stall;
        push_aw(32'h00001ff0, 8'd3, 3'd2);
        push_w(32'ha1, 4'hf, 1'b0); push_w(32'hb2, 4'hf, 1'b0);
        push_w(32'hc3, 4'hf, 1'b0); push_w(32'hd4, 4'hf, 1'b1);
        issue(3'b100, 32'h00001ffc, 4'b0001, {32'hd4, 32'hc3, 32'hb2, 32'ha1});
        wait_done(n);
        check("bp_aw_stall", aw_stall - base, 3);
        check("bp_cycles", n, 14);
        check_drained("bp");
        aw_delay = 0; w_toggle = 0;

        // Late response on a word write
        b_delay = 5;
        push_aw(32'h00001008, 8'd0, 3'd2);
        push_w(32'h5a5a0001, 4'hf, 1'b1);
        issue(3'b010, 32'h00001008, 4'hf, {96'h0, 32'h5a5a0001});
        n = 1; nresp = 0;
        while (!wr_rdy && n < 200) begin
            if (bready) begin
                nresp++;
                check("late_busy_rdy", {wr_busy, wr_rdy}, 2'b10);
            end
            @(posedge clk); #1; n++;
        end
        check("late_resp_cycles", nresp, 6);
        check("late_cycles", n, 9);
        check_drained("late");
        b_delay = 0;

        // Reset in the middle of the data phase, after the first beat
        push_aw(32'h30000040, 8'd3, 3'd2);
        push_w(32'h01, 4'hf, 1'b0); push_w(32'h02, 4'hf, 1'b0);
        push_w(32'h03, 4'hf, 1'b0); push_w(32'h04, 4'hf, 1'b1);
        issue(3'b100, 32'h30000040, 4'hf, {32'h04, 32'h03, 32'h02, 32'h01});
        n = 0;
        while (!wvalid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        check("midrst_outputs", {wvalid, awvalid, bready, wlast, wr_busy, wr_rdy}, 6'b000000);
        check("midrst_busy_addr", wr_busy_addr, 32'd0);
        check("midrst_w_left", 64'(exp_w.size()), 64'd3);
        exp_w.delete();
        exp_aw.delete();
        #1 resetn = 1'b1;
        #1 check("midrst_rdy_low", wr_rdy, 1'b0);
        @(posedge clk); #1;
        check("midrst_rdy_back", wr_rdy, 1'b1);
        push_aw(32'h20000014, 8'd0, 3'd2);
        push_w(32'hcafef00d, 4'b0011, 1'b1);
        issue(3'b010, 32'h20000014, 4'b0011, {96'h0, 32'hcafef00d});
        wait_done(n);
        check("midrst_new_cycles", n, 4);
        check_drained("midrst");

        // wr_req held through a busy transaction, inputs changing after acceptance
        base = aw_hs;
        push_aw(32'h00000041, 8'd0, 3'd0);
        push_w(32'h0000aa00, 4'b0010, 1'b1);
        push_aw(32'h00000080, 8'd0, 3'd2);
        push_w(32'h12345678, 4'hf, 1'b1);
        wr_type = 3'b000; wr_addr = 32'h00000041; wr_wstrb = 4'b0010;
        wr_data = {96'h0, 32'h0000aa00}; wr_req = 1'b1;
        @(posedge clk); #1;
        wr_type = 3'b010; wr_addr = 32'h00000080; wr_wstrb = 4'hf;
        wr_data = {96'h0, 32'h12345678};
        check("hold_busy_addr_a", wr_busy_addr, 32'h00000040);
        wait_done(n);
        check("hold_first_cycles", n, 4);
        @(posedge clk); #1;
        wr_req = 1'b0;
        check("hold_second_busy", {wr_busy, wr_rdy}, 2'b10);
        check("hold_busy_addr_b", wr_busy_addr, 32'h00000080);
        wait_done(n);
        check("hold_second_cycles", n, 4);
        repeat (3) @(posedge clk);
        #1;
        check("hold_aw_count", aw_hs - base, 2);
        check("hold_idle", {wr_busy, wr_rdy}, 2'b01);
        check_drained("hold");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
